jtcop_obj_dma: RTL and testbench
================================

Name: jtcop_obj_dma

Overview:
- Reader-side counterpart of the CPU-written object RAM buffer. It drives the buffer's second (read) port.
- On a DMA trigger from the CPU, it copies the whole object table into the sprite engine's private table RAM.
- The sprite engine then scans a stable snapshot, while the CPU keeps writing the live table.
- Sits between the object RAM buffer (port 1, system clock domain) and the object line renderer.

Parameters:
- AW, 10, word-address width of the object table; a copy moves 2**AW 16-bit words.
- DW, 16, data word width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- obj_copy  in  1  DMA request; level input, rising edge triggers a copy.
- ram_addr  out  AW  read address to the object RAM buffer port 1.
- ram_dout  in  DW  read data from port 1; synchronous RAM, valid one clk after ram_addr.
- tbl_addr  out  AW (AW+1 with bank option)  write address into the sprite table RAM.
- tbl_din  out  DW  write data into the sprite table RAM.
- tbl_we  out  1  write strobe into the sprite table RAM.
- busy  out  1  copy in progress.
- done  out  1  one-clk pulse after the last word is written.

Behaviour:
- Reset values: ram_addr=0, tbl_addr=0, tbl_din=0, tbl_we=0, busy=0, done=0. Internal state is IDLE, pending=0, and the edge-detect register is 0.
- Trigger: edge = obj_copy & ~obj_copy_l, with obj_copy_l registered every clk.
- State machine has three states: IDLE, READ and DRAIN.
- IDLE -> READ on edge, or when pending=1. At that transition:
  - busy<=1 and ram_addr<=0.
  - pending is cleared.
- READ:
  - ram_addr increments by 1 each clk.
  - A one-deep pipeline register carries the address: rd_valid and rd_addr hold the previously issued address.
  - Whenever rd_valid=1: tbl_we<=1, tbl_addr<=rd_addr, tbl_din<=ram_dout.
  - When ram_addr = 2**AW-1 has been issued, go to DRAIN. ram_addr holds at all-ones and does not wrap.
- DRAIN: the final word is written on this clk. Then go to IDLE with busy<=0, done<=1 for one clk, and tbl_we<=0.
- Timing for an edge sampled at clk 0 (AW=10):
  - busy high from clk 1.
  - Address 0 presented in clk 1.
  - First tbl_we in clk 3.
  - Last write (addr 1023) in clk 1026.
  - done and busy low in clk 1027.
  - Total of 1024 writes, one per clk, with no gaps.
- tbl_we is low in all cycles outside the write window.
- Trigger while busy: sets pending=1; multiple triggers collapse into one. After done, a new copy starts immediately from IDLE, so busy drops for exactly one clk.
- Trigger in the same clk as done: counts as pending.
- Async reset mid-copy: all outputs return to reset values immediately and pending is cleared. A partially copied table is left as is.
- Data width is pass-through: no transformation or byte masking.

Optional Feature:
- Macro JTCOP_OBJ_DMA_BANK_EN.
- When defined:
  - tbl_addr is AW+1 bits wide; the MSB is the write bank.
  - Extra output port tbl_bank (1 bit, reset 0) is the bank the renderer reads.
  - Each copy writes to bank ~tbl_bank.
  - tbl_bank toggles in the same clk done is asserted.
  - The renderer therefore never sees a half-written table.
- When undefined:
  - tbl_addr is AW bits and tbl_bank does not exist.
  - The copy overwrites the single table in place.

Decomposition:
- Shared package jtcop_obj_pkg holds:
  - the state enum (IDLE, READ, DRAIN);
  - the object-table constants OBJ_AW=10 and OBJ_DW=16;
  - the word count localparam 2**OBJ_AW.
- No sub-module: the edge detector, counter and one-stage pipeline stay in one file.

Test Plan:
- Reset then idle: rst_n low then high, obj_copy=0 for 2000 clk -> tbl_we, busy and done stay 0; ram_addr=0.
- Single copy: preload RAM model word i = i^16'hA5A5, pulse obj_copy -> exactly 1024 writes:
  - tbl_addr 0..1023 in order with tbl_din = i^16'hA5A5;
  - first write 3 clk after the edge;
  - done pulse at clk 1027, busy low the same clk.
- Level hold: keep obj_copy high for 5000 clk -> exactly one copy (1024 writes), with no retrigger.
- Retrigger while busy: edges at clk 100 and clk 500 of a copy -> one extra copy starts right after done. Total 2048 writes, done pulses 2, busy low for exactly 1 clk between copies.
- Reset mid-copy: deassert rst_n at write 300 -> tbl_we and busy drop asynchronously. After release, no activity until a new edge; a new edge gives a full 1024-word copy starting at address 0.
- With JTCOP_OBJ_DMA_BANK_EN: two copies -> first copy writes tbl_addr[10]=1 and tbl_bank becomes 1 at its done. Second copy writes tbl_addr[10]=0 and tbl_bank returns to 0.

Source files
------------

// File: rtl/jtcop_obj_pkg.sv
// Shared definitions for the object-table DMA: table geometry and the
// copy state machine encoding.
package jtcop_obj_pkg;

    localparam int OBJ_AW    = 10;
    localparam int OBJ_DW    = 16;
    localparam int OBJ_WORDS = 2 ** OBJ_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } obj_dma_state_t;

endpackage

// File: rtl/jtcop_obj_dma.sv
// Object-table DMA. On a rising edge of obj_copy it streams every word of the
// CPU-side object RAM (read port 1) into the sprite engine's private table,
// so the renderer scans a stable snapshot while the CPU keeps writing.
//
// Optional build macro JTCOP_OBJ_DMA_BANK_EN: double-buffers the sprite
// table. tbl_addr gains a bank MSB, each copy fills the bank the renderer is
// not reading, and tbl_bank flips together with done.
//
// Handshake: there is no back-pressure. obj_copy is a level; its rising edge
// requests one copy. busy is high from the clk after the request until done.
// Requests seen while busy (including the clk that ends the copy) collapse
// into a single pending copy that starts right after done. tbl_we is a
// one-clk write strobe qualifying tbl_addr/tbl_din, never high outside a copy.
module jtcop_obj_dma
    import jtcop_obj_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          obj_copy,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
`ifdef JTCOP_OBJ_DMA_BANK_EN
    output logic [AW:0]   tbl_addr,
    output logic          tbl_bank,
`else
    output logic [AW-1:0] tbl_addr,
`endif
    output logic [DW-1:0] tbl_din,
    output logic          tbl_we,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    obj_dma_state_t state, state_next;

    logic          obj_copy_l;
    logic          copy_edge;
    logic          pending;
    logic          start;
    logic          finish;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;

    assign copy_edge = obj_copy & ~obj_copy_l;
    assign dbg_state = state;

    // Next-state decode plus the start/finish strobes used by the datapath.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (copy_edge || pending) begin
                    state_next = READ;
                    start      = 1'b1;
                end
            end
            READ: begin
                // The last address is out; only the pipeline remains to empty.
                if (ram_addr == {AW{1'b1}}) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Exit once the final word has left the read pipeline.
                if (!rd_valid) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request edge detection and the single-entry pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_copy_l <= 1'b0;
            pending    <= 1'b0;
        end else begin
            obj_copy_l <= obj_copy;
            if (start) begin
                pending <= 1'b0;
            end else if (copy_edge && state != IDLE) begin
                pending <= 1'b1;
            end
        end
    end

    // Read address counter; parks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
        end else if (start) begin
            ram_addr <= '0;
        end else if (state == READ && ram_addr != {AW{1'b1}}) begin
            ram_addr <= ram_addr + 1'b1;
        end
    end

    // One-deep pipeline matching the synchronous RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
        end else begin
            rd_valid <= (state == READ);
            rd_addr  <= ram_addr;
        end
    end

    // Table write port: the word read last clk lands at its own address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_we   <= 1'b0;
            tbl_addr <= '0;
            tbl_din  <= '0;
        end else begin
            tbl_we <= rd_valid;
            if (rd_valid) begin
`ifdef JTCOP_OBJ_DMA_BANK_EN
                tbl_addr <= {~tbl_bank, rd_addr};
`else
                tbl_addr <= rd_addr;
`endif
                tbl_din  <= ram_dout;
            end
        end
    end

    // Copy status: busy across the copy, done for one clk at its end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (start) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef JTCOP_OBJ_DMA_BANK_EN
    // Hand the freshly written bank to the renderer as the copy completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_bank <= 1'b0;
        end else if (finish) begin
            tbl_bank <= ~tbl_bank;
        end
    end
`endif

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Bench for jtcop_obj_dma: synchronous RAM model on port 1, a negedge monitor
// logging table writes / done / busy transitions, and a reference model that
// predicts every copy as a list of (address, data, cycle) entries.
`timescale 1ns/1ps
module tb_jtcop_obj_dma;
    import jtcop_obj_pkg::*;

    localparam int AW    = OBJ_AW;
    localparam int DW    = OBJ_DW;
    localparam int WORDS = OBJ_WORDS;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          obj_copy = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
`ifdef JTCOP_OBJ_DMA_BANK_EN
    logic [AW:0]   tbl_addr;
    logic          tbl_bank;
`else
    logic [AW-1:0] tbl_addr;
`endif
    logic [DW-1:0] tbl_din;
    logic          tbl_we;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] mem [WORDS];

    // Observed activity
    int            wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            done_cyc_q[$];
    int            done_bank_q[$];
    int            busy_rise_q[$];
    int            busy_fall_q[$];
    logic          busy_prev = 1'b0;

    // Expected activity
    logic [DW-1:0] exp_q[$];
    int            exp_addr_q[$];
    int            exp_cyc_q[$];
    int            exp_done_q[$];
    int            model_bank = 0;
    int            first_bad  = -1;

    jtcop_obj_dma dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .obj_copy  (obj_copy),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
`ifdef JTCOP_OBJ_DMA_BANK_EN
        .tbl_addr  (tbl_addr),
        .tbl_bank  (tbl_bank),
`else
        .tbl_addr  (tbl_addr),
`endif
        .tbl_din   (tbl_din),
        .tbl_we    (tbl_we),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock / cycle counter / RAM model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram_dout <= mem[ram_addr];

    function automatic int bank_now();
`ifdef JTCOP_OBJ_DMA_BANK_EN
        return int'(tbl_bank);
`else
        return 0;
`endif
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (tbl_we) begin
                wr_addr_q.push_back(int'(tbl_addr));
                wr_data_q.push_back(tbl_din);
                wr_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cyc_q.push_back(cyc);
                done_bank_q.push_back(bank_now());
            end
            if (busy && !busy_prev) busy_rise_q.push_back(cyc);
            if (!busy && busy_prev) busy_fall_q.push_back(cyc);
        end
        busy_prev <= busy;
    end

    task automatic clear_all();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        done_cyc_q.delete(); done_bank_q.delete();
        busy_rise_q.delete(); busy_fall_q.delete();
        exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete(); exp_done_q.delete();
    endtask

    // Reference model: a copy requested in clk t writes word i at clk t+3+i
    // into the bank not being displayed, and signals done one clk after.
    task automatic model_copy(input int t_start);
        int wb;
`ifdef JTCOP_OBJ_DMA_BANK_EN
        wb = 1 - model_bank;
`else
        wb = 0;
`endif
        for (int i = 0; i < WORDS; i++) begin
            exp_q.push_back(mem[i]);
            exp_addr_q.push_back(wb * WORDS + i);
            exp_cyc_q.push_back(t_start + 3 + i);
        end
        exp_done_q.push_back(t_start + WORDS + 3);
        model_bank = wb;
    endtask

    // Scoreboard: number of logged writes disagreeing with the expected list.
    function automatic int count_bad_writes();
        int bad = 0;
        int n;
        first_bad = -1;
        n = (wr_data_q.size() > exp_q.size()) ? wr_data_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= wr_data_q.size() || i >= exp_q.size() ||
                wr_data_q[i] !== exp_q[i] || wr_addr_q[i] != exp_addr_q[i] ||
                wr_cyc_q[i] != exp_cyc_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return bad;
    endfunction

    task automatic wait_done(input int n, input int budget, output bit ok);
        int k = 0;
        while (done_cyc_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (done_cyc_q.size() >= n);
    endtask

    task automatic fill_random();
        for (int i = 0; i < WORDS; i++) mem[i] = DW'($urandom_range(0, 65535));
    endtask

    // Start a copy with a one-clk request pulse; returns the request clk.
    task automatic pulse_copy(output int t0);
        @(negedge clk);
        obj_copy = 1'b1;
        t0 = cyc;
        @(negedge clk);
        obj_copy = 1'b0;
    endtask

    task automatic test_reset();
        int viol = 0;
        rst_n = 1'b0;
        obj_copy = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ram_addr !== '0) begin failures++; $display("FAIL reset_ram_addr got=%0h exp=0", ram_addr); end
        checks++; if (tbl_addr !== '0) begin failures++; $display("FAIL reset_tbl_addr got=%0h exp=0", tbl_addr); end
        checks++; if (tbl_din !== '0) begin failures++; $display("FAIL reset_tbl_din got=%0h exp=0", tbl_din); end
        checks++; if ({tbl_we, busy, done} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got we/busy/done=%b exp=000", {tbl_we, busy, done}); end
        checks++; if (bank_now() !== 0) begin failures++; $display("FAIL reset_bank got=%0d exp=0", bank_now()); end
        rst_n = 1'b1;
        model_bank = 0;
        clear_all();
        repeat (2000) begin
            @(negedge clk);
            if (tbl_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== '0) viol++;
        end
        checks++; if (viol !== 0) begin failures++; $display("FAIL idle_quiet got=%0d active_cycles exp=0", viol); end
    endtask

    task automatic test_single_copy();
        int t0, bad, v;
        bit ok;
        for (int i = 0; i < WORDS; i++) mem[i] = DW'(i) ^ 16'hA5A5;
        clear_all();
        pulse_copy(t0);
        model_copy(t0);
        wait_done(1, 1500, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=no_done exp=done"); end
        checks++; if (wr_data_q.size() !== WORDS) begin failures++; $display("FAIL single_count got=%0d exp=%0d", wr_data_q.size(), WORDS); end
        bad = count_bad_writes();
        checks++; if (bad !== 0) begin failures++; $display("FAIL single_writes got=%0d bad (first idx %0d) exp=0", bad, first_bad); end
        v = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - t0 : -1;
        checks++; if (v !== 3) begin failures++; $display("FAIL single_first_we got=%0d exp=3", v); end
        v = (done_cyc_q.size() > 0) ? done_cyc_q[0] - t0 : -1;
        checks++; if (v !== WORDS + 3) begin failures++; $display("FAIL single_done_clk got=%0d exp=%0d", v, WORDS + 3); end
        checks++; if (done_cyc_q.size() !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cyc_q.size()); end
        v = (busy_rise_q.size() > 0) ? busy_rise_q[0] - t0 : -1;
        checks++; if (v !== 1) begin failures++; $display("FAIL single_busy_rise got=%0d exp=1", v); end
        v = (busy_fall_q.size() > 0) ? busy_fall_q[0] - t0 : -1;
        checks++; if (v !== WORDS + 3) begin failures++; $display("FAIL single_busy_fall got=%0d exp=%0d", v, WORDS + 3); end
        checks++; if (bank_now() !== model_bank) begin failures++; $display("FAIL single_bank got=%0d exp=%0d", bank_now(), model_bank); end
    endtask

    task automatic test_level_hold();
        int t0, bad;
        fill_random();
        clear_all();
        @(negedge clk);
        obj_copy = 1'b1;
        t0 = cyc;
        model_copy(t0);
        repeat (5000) @(negedge clk);
        obj_copy = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (wr_data_q.size() !== WORDS) begin failures++; $display("FAIL hold_count got=%0d exp=%0d", wr_data_q.size(), WORDS); end
        bad = count_bad_writes();
        checks++; if (bad !== 0) begin failures++; $display("FAIL hold_writes got=%0d bad (first idx %0d) exp=0", bad, first_bad); end
        checks++; if (done_cyc_q.size() !== 1) begin failures++; $display("FAIL hold_done_count got=%0d exp=1", done_cyc_q.size()); end
    endtask

    task automatic test_back_to_back();
        int t0, t2, bad, gap, d0, d1;
        bit ok;
        fill_random();
        clear_all();
        t2 = $urandom_range(200, 1000);
        pulse_copy(t0);
        model_copy(t0);
        model_copy(t0 + WORDS + 3);
        while (cyc < t0 + 100) @(negedge clk);
        obj_copy = 1'b1;
        @(negedge clk);
        obj_copy = 1'b0;
        while (cyc < t0 + t2) @(negedge clk);
        obj_copy = 1'b1;
        @(negedge clk);
        obj_copy = 1'b0;
        wait_done(2, 3000, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d dones exp=2", done_cyc_q.size()); end
        checks++; if (wr_data_q.size() !== 2 * WORDS) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", wr_data_q.size(), 2 * WORDS); end
        bad = count_bad_writes();
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_writes got=%0d bad (first idx %0d) exp=0", bad, first_bad); end
        checks++; if (done_cyc_q.size() !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cyc_q.size()); end
        d0 = (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1;
        d1 = (done_cyc_q.size() > 1) ? done_cyc_q[1] : -1;
        checks++; if (d0 !== exp_done_q[0] || d1 !== exp_done_q[1]) begin failures++; $display("FAIL b2b_done_clk got=%0d,%0d exp=%0d,%0d", d0, d1, exp_done_q[0], exp_done_q[1]); end
        gap = (busy_rise_q.size() > 1 && busy_fall_q.size() > 0) ? busy_rise_q[1] - busy_fall_q[0] : -1;
        checks++; if (gap !== 1) begin failures++; $display("FAIL b2b_busy_gap got=%0d exp=1", gap); end
        checks++; if (bank_now() !== model_bank) begin failures++; $display("FAIL b2b_bank got=%0d exp=%0d", bank_now(), model_bank); end
    endtask

    task automatic test_reset_mid_copy();
        int t0, k, bad;
        bit ok;
        fill_random();
        clear_all();
        pulse_copy(t0);
        k = 0;
        while (wr_data_q.size() < 300 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        checks++; if (wr_data_q.size() < 300) begin failures++; $display("FAIL rstmid_reach got=%0d writes exp=300", wr_data_q.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if ({tbl_we, busy, done} !== 3'b000) begin failures++; $display("FAIL rstmid_async got we/busy/done=%b exp=000", {tbl_we, busy, done}); end
        checks++; if (ram_addr !== '0 || tbl_addr !== '0) begin failures++; $display("FAIL rstmid_addr got=%0h/%0h exp=0/0", ram_addr, tbl_addr); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_bank = 0;
        clear_all();
        repeat (50) @(negedge clk);
        checks++; if (wr_data_q.size() !== 0 || busy_rise_q.size() !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d writes %0d busy exp=0 0", wr_data_q.size(), busy_rise_q.size()); end
        pulse_copy(t0);
        model_copy(t0);
        wait_done(1, 1500, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got=no_done exp=done"); end
        bad = count_bad_writes();
        checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_recopy got=%0d bad (first idx %0d) exp=0", bad, first_bad); end
    endtask

`ifdef JTCOP_OBJ_DMA_BANK_EN
    task automatic test_bank();
        int t0, wrong;
        bit ok;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_bank = 0;
        fill_random();
        for (int c = 0; c < 2; c++) begin
            clear_all();
            pulse_copy(t0);
            wait_done(1, 1500, ok);
            repeat (3) @(negedge clk);
            wrong = 0;
            foreach (wr_addr_q[i]) if ((wr_addr_q[i] >> AW) != 1 - c) wrong++;
            checks++; if (!ok || wr_addr_q.size() !== WORDS || wrong !== 0) begin failures++; $display("FAIL bank_write copy%0d got=%0d writes %0d wrong_bank exp=%0d 0", c, wr_addr_q.size(), wrong, WORDS); end
            checks++; if (done_bank_q.size() !== 1 || done_bank_q[0] !== 1 - c) begin failures++; $display("FAIL bank_at_done copy%0d got=%0d exp=%0d", c, bank_now(), 1 - c); end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
        test_reset();
        test_single_copy();
        test_level_hold();
        test_back_to_back();
        test_reset_mid_copy();
`ifdef JTCOP_OBJ_DMA_BANK_EN
        test_bank();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
